// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Optional feature macro used by the divider: DIV_SIGNED_EN.
package div_pkg;

   localparam int unsigned DIV_WIDTH     = 32;
   localparam int unsigned DIV_ITERS     = 32;
   localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } div_state_t;

endpackage

// File: rtl/div_sub33.sv
// Trial subtractor for one restoring-division step.
// Callers keep a < 2*b, so the sign bit of the 33-bit difference is the borrow
// and the low 32 bits hold the full new remainder whenever there is no borrow.
module div_sub33
   import div_pkg::*;
(
   input  logic [DIV_WIDTH:0]   a,
   input  logic [DIV_WIDTH-1:0] b,
   output logic                 borrow,
   output logic [DIV_WIDTH-1:0] diff
);

   logic [DIV_WIDTH:0] full;

   assign full   = a - {1'b0, b};
   assign borrow = full[DIV_WIDTH];
   assign diff   = full[DIV_WIDTH-1:0];

endmodule

// File: rtl/seq_divider32.sv
// 32-bit multi-cycle restoring divider, one quotient bit per cycle, with
// valid/ready handshakes on operands and results.
// Feature macro DIV_SIGNED_EN: two's-complement operands (magnitudes at
// accept, sign fix-up when the result is latched). Undefined: unsigned only.
module seq_divider32
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CNT_W = $clog2(DIV_ITERS);

   div_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] quot_q, quot_d;          // dividend / quotient shift register
   logic [WIDTH-1:0] rem_q, rem_d;            // partial remainder (always < divisor)
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] res_quot_q, res_quot_d;
   logic [WIDTH-1:0] res_rem_q, res_rem_d;
   logic             dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
`endif

   logic [WIDTH:0]   shifted;
   logic             borrow;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] step_quot;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;

   assign shifted = {rem_q, quot_q[WIDTH-1]};

   div_sub33 u_sub (
      .a      (shifted),
      .b      (dvs_q),
      .borrow (borrow),
      .diff   (diff)
   );

   // On borrow the shifted value is below the divisor, so its top bit is zero.
   assign step_quot = {quot_q[WIDTH-2:0], ~borrow};
   assign step_rem  = borrow ? shifted[WIDTH-1:0] : diff;

`ifdef DIV_SIGNED_EN
   assign dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
   assign dvs_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
`else
   assign dvd_mag = dividend;
   assign dvs_mag = divisor;
`endif

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign quotient    = res_quot_q;
   assign remainder   = res_rem_q;
   assign div_by_zero = dbz_q;

   // Next-state, datapath step and result capture.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      dvs_d      = dvs_q;
      res_quot_d = res_quot_q;
      res_rem_d  = res_rem_q;
      dbz_d      = dbz_q;
`ifdef DIV_SIGNED_EN
      qneg_d     = qneg_q;
      rneg_d     = rneg_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (divisor == '0) begin
                  state_d    = DONE;
                  res_quot_d = DIV_ZERO_QUOT;
                  res_rem_d  = dividend;
                  dbz_d      = 1'b1;
               end else begin
                  state_d = BUSY;
                  quot_d  = dvd_mag;
                  rem_d   = '0;
                  dvs_d   = dvs_mag;
                  cnt_d   = CNT_W'(DIV_ITERS - 1);
                  dbz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
                  qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  rneg_d  = dividend[WIDTH-1];
`endif
               end
            end
         end
         BUSY: begin
            quot_d = step_quot;
            rem_d  = step_rem;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = DONE;
`ifdef DIV_SIGNED_EN
               res_quot_d = qneg_q ? (~step_quot + 1'b1) : step_quot;
               res_rem_d  = rneg_q ? (~step_rem + 1'b1)  : step_rem;
`else
               res_quot_d = step_quot;
               res_rem_d  = step_rem;
`endif
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
         dvs_q      <= '0;
         res_quot_q <= '0;
         res_rem_q  <= '0;
         dbz_q      <= 1'b0;
`ifdef DIV_SIGNED_EN
         qneg_q     <= 1'b0;
         rneg_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         dvs_q      <= dvs_d;
         res_quot_q <= res_quot_d;
         res_rem_q  <= res_rem_d;
         dbz_q      <= dbz_d;
`ifdef DIV_SIGNED_EN
         qneg_q     <= qneg_d;
         rneg_q     <= rneg_d;
`endif
      end
   end

endmodule
